uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive engine that consumes the single-wire line produced by the team's UART transmit path, sitting directly downstream of it. It synchronises the asynchronous `rx_in`, detects start bits using the baud generator's oversampled receive tick, deserialises 8N1 frames LSB-first, and presents each byte with a one-cycle valid pulse to the receive FIFO. Framing errors are flagged. Parity checking is optional.

## Interface
- `OVERSAMPLE`, 16: `baud_tick` pulses per bit period. Must be an even number, 8–32.
- `PARITY_ODD`, 0: parity sense when parity is compiled in. 0 = even, 1 = odd.
- `clk` in 1: single system clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `baud_tick` in 1: one-`clk`-wide enable at OVERSAMPLE × baud, driven from the `baud_gen` receive output.
- `rx_in` in 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` out 8: last correctly framed byte. Held until the next good frame.
- `rx_valid` out 1: one-`clk` pulse when `rx_data` updates.
- `frame_err` out 1: one-`clk` pulse when the stop bit is sampled low.
- `parity_err` out 1: one-`clk` pulse when parity mismatches. Tied to 0 when parity is compiled out.
- `rx_busy` out 1: high in every state except IDLE.

## Operation
- `rx_in` passes through a 2-FF synchroniser (reset value 1). All decisions use the synchronised value `rx_s`.
- Counters:
  - `tick_cnt`: clog2(OVERSAMPLE) bits, counts `baud_tick` only.
  - `bit_cnt`: 3 bits.
  - `shreg`: 8 bits.
- FSM states, with transitions evaluated only on `clk` edges where `baud_tick` = 1:
  - IDLE: if `rx_s` = 0, go to START with `tick_cnt` = 0.
  - START: at `tick_cnt` = OVERSAMPLE/2−1, re-sample the line.
    - Low: go to DATA with `tick_cnt` = 0 and `bit_cnt` = 0.
    - High: glitch. Return to IDLE with no output.
  - DATA: at `tick_cnt` = OVERSAMPLE−1, shift `rx_s` into `shreg[7]` (right shift, so the LSB arrives first), then increment `bit_cnt`. After the bit with `bit_cnt` = 7, go to PARITY if it is compiled in, otherwise to STOP.
  - PARITY: at `tick_cnt` = OVERSAMPLE−1, latch the sampled parity bit and go to STOP.
  - STOP: at `tick_cnt` = OVERSAMPLE−1, sample the line.
    - High: load `rx_data` with `shreg` and pulse `rx_valid`. If the parity check fails, also pulse `parity_err`. Go to IDLE.
    - Low: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay here until `rx_s` = 1, then go to IDLE. This prevents a break condition from retriggering reception.
- `tick_cnt` wraps to 0 at every sample point, so sampling is mid-bit throughout.
- `baud_tick` low: all state, counters and outputs hold, except that the pulse outputs clear.
- Error pulses are not mutually exclusive with `rx_valid`: on a parity fault, `rx_valid` and `parity_err` assert in the same cycle.

## Timing
- Reset values:
  - State = IDLE.
  - `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `rx_busy` = 0.
  - Synchroniser = 1, and all counters = 0.
- Latency from `rx_in` edge to `rx_s`: 2 `clk`.
- `rx_valid`, `frame_err` and `parity_err` are registered. Each asserts in the `clk` cycle after the `baud_tick` edge that samples the stop bit, and deasserts one cycle later.
- Back-to-back frames: a start bit that immediately follows a good stop bit is detected on the first tick in IDLE. No dead time is required.
- Reset mid-frame aborts immediately. No partial output is produced. Reception resumes at the next start bit after `reset_n` rises.
- Minimum glitch rejected: any low pulse shorter than OVERSAMPLE/2 ticks.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state is present and the frame is 8 data bits + 1 parity bit + 1 stop bit. Parity is computed over the 8 data bits per `PARITY_ODD`, and `parity_err` is live.
  - Undefined: the frame is 8N1, the PARITY state is absent, and `parity_err` is constant 0.

## Structure
- Package `uart_rx_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - `RX_DATA_W` = 8.
  - `OVERSAMPLE_DEFAULT` = 16.
- One sub-module, `uart_rx_sync`: a 2-FF synchroniser with a parameterised reset value, instantiated once for `rx_in`.

## Test plan
- Frame 0xA5, 8N1, OVERSAMPLE = 16 → exactly one `rx_valid` pulse, `rx_data` = 0xA5, `frame_err` = 0.
- `rx_in` low for 5 ticks, then high → no `rx_valid`, `rx_busy` returns to 0, FSM in IDLE.
- Frame 0x3C with stop bit driven low → `frame_err` pulse, `rx_data` keeps its previous value, and no new frame until the line returns high.
- Frames 0x00 then 0xFF back-to-back with no idle gap → two `rx_valid` pulses, carrying 0x00 then 0xFF.
- `reset_n` asserted during data bit 4 of 0x81 → no output, and outputs at reset values. The following frame 0x55 is received correctly.
- With `UART_RX_PARITY_EN` and `PARITY_ODD` = 0, frame 0x07 with parity bit 0 → `rx_valid` and `parity_err` in the same cycle, `rx_data` = 0x07.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types, constants and helpers for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

   localparam int RX_DATA_W          = 8;
   localparam int OVERSAMPLE_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_t;

   // High when the data bits plus the received parity bit disagree with the
   // selected sense (odd = 0 expects an even count of ones overall).
   function automatic logic parity_fail(input logic [RX_DATA_W-1:0] data,
                                        input logic par_bit,
                                        input logic odd);
      return ((^data) ^ par_bit) != odd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser with a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic [1:0] r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {2{RST_VAL}};
      end else begin
         r_sync <= {r_sync[0], async_in};
      end
   end

   assign sync_out = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// Module      : uart_rx_core
// Description : Oversampled UART receiver, 8 data bits LSB-first, one stop bit.
//               Define UART_RX_PARITY_EN to add a parity bit and parity_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core
   import uart_rx_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic                 rx_in,
   output logic [RX_DATA_W-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 rx_busy
);

   localparam int                 c_tick_w   = $clog2(OVERSAMPLE);
   localparam logic [c_tick_w-1:0] c_tick_mid = c_tick_w'(OVERSAMPLE / 2 - 1);
   localparam logic [c_tick_w-1:0] c_tick_end = c_tick_w'(OVERSAMPLE - 1);
   localparam logic [c_tick_w-1:0] c_tick_one = c_tick_w'(1);

   logic                 w_rx_s;
   rx_state_t            r_state;
   logic [c_tick_w-1:0]  r_tick_cnt;
   logic [2:0]           r_bit_cnt;
   logic [RX_DATA_W-1:0] r_shreg;
   logic [RX_DATA_W-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_frame_err;
   logic                 r_parity_err;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bit;
`else
   logic                 w_unused_parity_odd;
   assign w_unused_parity_odd = PARITY_ODD;
`endif

   uart_rx_sync #(
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (rx_in),
      .sync_out (w_rx_s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shreg      <= '0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
`endif
      end else begin
         // Pulse outputs last exactly one clk regardless of tick spacing.
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         if (baud_tick) begin
            case (r_state)
               IDLE: begin
                  if (!w_rx_s) begin
                     r_state    <= START;
                     r_tick_cnt <= '0;
                  end
               end
               START: begin
                  if (r_tick_cnt == c_tick_mid) begin
                     r_tick_cnt <= '0;
                     r_bit_cnt  <= '0;
                     r_state    <= w_rx_s ? IDLE : DATA;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + c_tick_one;
                  end
               end
               DATA: begin
                  if (r_tick_cnt == c_tick_end) begin
                     r_tick_cnt <= '0;
                     r_shreg    <= {w_rx_s, r_shreg[RX_DATA_W-1:1]};
                     r_bit_cnt  <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= STOP;
`endif
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + c_tick_one;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (r_tick_cnt == c_tick_end) begin
                     r_tick_cnt <= '0;
                     r_par_bit  <= w_rx_s;
                     r_state    <= STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + c_tick_one;
                  end
               end
`endif
               STOP: begin
                  if (r_tick_cnt == c_tick_end) begin
                     r_tick_cnt <= '0;
                     if (w_rx_s) begin
                        r_rx_data  <= r_shreg;
                        r_rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= parity_fail(r_shreg, r_par_bit, PARITY_ODD);
`endif
                        r_state    <= IDLE;
                     end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= WAIT_HIGH;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + c_tick_one;
                  end
               end
               // A held-low line (break) must not look like a fresh start bit.
               WAIT_HIGH: begin
                  if (w_rx_s) begin
                     r_state <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign rx_busy    = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Directed self-checking bench for uart_rx_core (16x oversample).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

   localparam int TICK_DIV = 4;
   localparam int OS       = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_tick;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       rx_busy;

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_valid = 0;
   int         n_ferr = 0;
   int         n_perr = 0;
   int         n_perr_with_valid = 0;
   logic [7:0] got_q[$];
   int         tick_div = 0;

   uart_rx_core #(
      .OVERSAMPLE (OS),
      .PARITY_ODD (1'b0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .baud_tick  (baud_tick),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .rx_busy    (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tick_div <= (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
   end
   assign baud_tick = (tick_div == TICK_DIV - 1);

   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid++;
         got_q.push_back(rx_data);
         if (parity_err) n_perr_with_valid++;
      end
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * TICK_DIV) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      wait_ticks(OS);
   endtask

   // par_bad inverts the correct even-parity bit when parity is compiled in.
   task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_bad);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^data) ^ par_bad);
`else
      if (par_bad) rx_in = 1'b1;
`endif
      send_bit(stop_val);
   endtask

   function automatic logic [31:0] q_at(input int idx);
      if (got_q.size() > idx) return {24'h0, got_q[idx]};
      return 32'hDEAD;
   endfunction

   int v0, f0, p0;

   initial begin
      repeat (5) @(negedge clk);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_parity_err", parity_err, 1'b0);
      check("reset_rx_busy", rx_busy, 1'b0);
      reset_n = 1'b1;
      wait_ticks(OS);

      // Single good frame
      v0 = n_valid; f0 = n_ferr; p0 = n_perr; got_q.delete();
      send_frame(8'hA5, 1'b1, 1'b0);
      wait_ticks(4);
      check("a5_valid_count", n_valid - v0, 1);
      check("a5_data_port", rx_data, 8'hA5);
      check("a5_data_pulse", q_at(0), 8'hA5);
      check("a5_frame_err", n_ferr - f0, 0);
      check("a5_parity_err", n_perr - p0, 0);

      // Short low glitch
      v0 = n_valid;
      rx_in = 1'b0;
      wait_ticks(3);
      check("glitch_busy_mid", rx_busy, 1'b1);
      wait_ticks(2);
      rx_in = 1'b1;
      wait_ticks(OS);
      check("glitch_no_valid", n_valid - v0, 0);
      check("glitch_busy_end", rx_busy, 1'b0);

      // Stop bit low, line then held low (break)
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 1'b0);
      wait_ticks(2 * OS);
      check("ferr_count", n_ferr - f0, 1);
      check("ferr_no_valid", n_valid - v0, 0);
      check("ferr_data_held", rx_data, 8'hA5);
      check("ferr_wait_high_busy", rx_busy, 1'b1);
      rx_in = 1'b1;
      wait_ticks(OS);
      check("ferr_idle_after_high", rx_busy, 1'b0);
      check("ferr_still_no_valid", n_valid - v0, 0);

      // Back-to-back frames
      v0 = n_valid; got_q.delete();
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      wait_ticks(4);
      check("b2b_valid_count", n_valid - v0, 2);
      check("b2b_first", q_at(0), 8'h00);
      check("b2b_second", q_at(1), 8'hFF);

      // Reset during data bit 4 of 0x81
      v0 = n_valid; f0 = n_ferr;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1 & (i == 0));
      rx_in = 1'b0;
      wait_ticks(OS / 2);
      reset_n = 1'b0;
      rx_in = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_mid_rx_data", rx_data, 8'h00);
      check("rst_mid_rx_valid", rx_valid, 1'b0);
      check("rst_mid_frame_err", frame_err, 1'b0);
      check("rst_mid_rx_busy", rx_busy, 1'b0);
      reset_n = 1'b1;
      wait_ticks(2 * OS);
      check("rst_no_valid", n_valid - v0, 0);
      check("rst_no_ferr", n_ferr - f0, 0);
      got_q.delete();
      send_frame(8'h55, 1'b1, 1'b0);
      wait_ticks(4);
      check("rst_next_valid", n_valid - v0, 1);
      check("rst_next_data", q_at(0), 8'h55);

`ifdef UART_RX_PARITY_EN
      // 0x07 with parity bit 0 under even parity
      v0 = n_valid; p0 = n_perr_with_valid; got_q.delete();
      send_frame(8'h07, 1'b1, 1'b1);
      wait_ticks(4);
      check("par_valid_count", n_valid - v0, 1);
      check("par_err_with_valid", n_perr_with_valid - p0, 1);
      check("par_data", q_at(0), 8'h07);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
